alu_muldiv_seq: RTL and testbench
=================================

# alu_muldiv_seq

Multi-cycle sequencer for the ALU's MUL, DIV and MOD operations. It replaces the single-cycle combinational multiply and divide paths with a radix-2 iterative datapath controlled by an FSM. It sits beside the ALU in the execute stage. The pipeline hands it one operation through a valid/ready request and stalls on `busy` until the response is consumed.

## Interface
Parameters:
- `XLEN`, default 32. Operand and result width. Only 32 is supported.
- `CNT_W`, default 5. Width of the iteration counter.

Ports:
- `clk`  in  1  System clock. Single clock domain.
- `rst`  in  1  Reset, asynchronous and active-high.
- `flush`  in  1  Synchronous abort of any in-flight operation.
- `req_valid`  in  1  Request present.
- `req_ready`  out  1  Sequencer can accept a request.
- `req_op`  in  `ALU_OP_LEN`  Operation: `ALU_OP_MUL`, `ALU_OP_DIV` or `ALU_OP_MOD`.
- `req_a`  in  32  Operand 1 (multiplicand or dividend), signed.
- `req_b`  in  32  Operand 2 (multiplier or divisor), signed.
- `resp_valid`  out  1  Result available.
- `resp_ready`  in  1  Consumer takes the result.
- `resp_data`  out  32  Result.
- `resp_zero`  out  1  High when `resp_data == 0`.
- `resp_neg`  out  1  Equal to `resp_data[31]`.
- `resp_dbz`  out  1  Divide by zero occurred (DIV or MOD).
- `resp_err`  out  1  `req_op` was not a supported operation.
- `busy`  out  1  High in every state except IDLE.

## Operation
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - `req_ready` is 1.
  - A request is accepted on an edge where `req_valid` is 1. That edge latches `req_op`, `req_a` and `req_b`, and the FSM moves to PREP.
- PREP:
  - Takes magnitudes of both operands and records the result sign. MUL result sign is `a[31]^b[31]`. DIV result sign is `a[31]^b[31]`. MOD result sign is `a[31]`.
  - Loads the counter with 31.
  - Next state is CALC in the normal case.
  - If the op is unsupported, or it is DIV/MOD with `b == 0`, next state is FIX.
- CALC, one iteration per cycle:
  - MUL: shift-add on a 64-bit accumulator.
  - DIV/MOD: restoring division with a 33-bit partial remainder.
  - The counter decrements each cycle. The FSM moves to FIX after the cycle in which the counter reads 0, giving exactly 32 iterations.
- FIX:
  - Applies sign correction and selects the result into the `resp_*` registers.
  - Next state is DONE.
- DONE:
  - `resp_valid` is 1.
  - All `resp_*` outputs are held stable until an edge where `resp_ready` is 1. The FSM then returns to IDLE.
- Arithmetic rules (two's complement):
  - MUL returns the low 32 bits of the full 64-bit product.
  - DIV truncates toward zero.
  - MOD takes the sign of the dividend and satisfies `a == q*b + r`.
- Boundary cases:
  - Divide by zero: DIV returns 0xFFFFFFFF, MOD returns `a`, `resp_dbz` is 1.
  - Overflow case 0x80000000 / 0xFFFFFFFF: DIV returns 0x80000000, MOD returns 0, no flag.
  - Unsupported op: `resp_data` is 0 and `resp_err` is 1.
- `flush`:
  - Has priority over every transition. The next edge forces IDLE and the in-flight result is discarded.
  - `flush` together with `req_valid` in IDLE: the request is not accepted.
- `rst`:
  - Asserting `rst` immediately forces IDLE and clears all registers, including in mid-operation.
  - Reset values: `req_ready` 1, `busy` 0, `resp_valid` 0, and `resp_data`, `resp_zero`, `resp_neg`, `resp_dbz`, `resp_err` all 0.
- While `resp_valid` is 0, the `resp_*` data outputs hold their previous values.

## Timing
- Edge numbering: edge 0 is the accepting edge.
- MUL/DIV/MOD, normal path:
  - PREP runs at edge 1.
  - CALC runs at edges 2 through 33.
  - FIX runs at edge 34.
  - `resp_valid` rises after edge 34.
  - Latency is 35 cycles from acceptance.
- Divide by zero and unsupported op:
  - PREP at edge 1, FIX at edge 2.
  - `resp_valid` rises after edge 2, a latency of 3 cycles.
- Minimum initiation interval is latency + 1. One cycle is spent in DONE with `resp_ready` = 1.
- There is no back-to-back acceptance in the DONE cycle. `req_ready` is 0 outside IDLE.
- All outputs come directly from registers, apart from `req_ready` and `busy`, which decode only the state register.

## Structure
- Add the following to the shared constants header `AlicePU_const.vh`:
  - State encodings `MD_ST_IDLE`, `MD_ST_PREP`, `MD_ST_CALC`, `MD_ST_FIX`, `MD_ST_DONE`, each 3 bits.
  - `MD_DBZ_QUOT` = 0xFFFFFFFF.
  - Reuse the existing `ALU_OP_*` codes; do not add new op codes.
- Sub-module `muldiv_step`, purely combinational, performs one radix-2 step:
  - Inputs: `is_div`, accumulator or remainder, operand.
  - Outputs: next accumulator/remainder and quotient bit.
- `alu_muldiv_seq` holds the FSM, the counter, the operand, sign and accumulator registers, and the FIX logic.

## Test plan
- MUL 7 × −3:
  - Response: 0xFFFFFFEB, `resp_neg` 1, `resp_valid` after exactly 35 cycles.
  - `req_ready`/`busy` toggle only at the edges given under Timing.
- DIV −7 / 2:
  - Response: 0xFFFFFFFD.
  - MOD −7 % 2 returns 0xFFFFFFFF.
  - MOD 7 % −2 returns 1.
- DIV 5 / 0:
  - Response: 0xFFFFFFFF, `resp_dbz` 1, 3-cycle latency.
  - MOD 5 % 0 returns 5.
- DIV 0x80000000 / 0xFFFFFFFF:
  - Response: 0x80000000.
  - MOD of the same operands returns 0 with `resp_zero` 1.
- Backpressure and flush:
  - Hold `resp_ready` at 0 for 10 cycles: the response stays stable with no new accept.
  - Assert `flush` in CALC at edge 10: IDLE follows, with no `resp_valid`.
- Async reset:
  - Assert `rst` between edges mid-CALC: all outputs take reset values before the next edge.
  - After release, MUL 0x10000 × 0x10000 returns 0.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared op codes, sequencer states and constants for the MUL/DIV/MOD sequencer.
package alu_muldiv_seq_pkg;

  localparam int unsigned ALU_OP_LEN = 4;

  localparam logic [ALU_OP_LEN-1:0] ALU_OP_MUL = 4'hA;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_DIV = 4'hB;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_MOD = 4'hC;

  localparam logic [31:0] MD_DBZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    MD_ST_IDLE = 3'd0,
    MD_ST_PREP = 3'd1,
    MD_ST_CALC = 3'd2,
    MD_ST_FIX  = 3'd3,
    MD_ST_DONE = 3'd4
  } md_state_e;

  // Two's complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] md_abs(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_step.sv
// One radix-2 step: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              qbit_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] sub;
  logic            ge;

  // Accumulator holds {high half, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem    = acc_i[2*XLEN-1:XLEN-1];
    ge     = (rem >= {1'b0, opnd_i});
    sub    = rem[XLEN-1:0] - opnd_i;
    acc_o  = '0;
    qbit_o = 1'b0;
    if (is_div) begin
      qbit_o = ge;
      acc_o  = {(ge ? sub : rem[XLEN-1:0]), acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o  = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative MUL/DIV/MOD sequencer with valid/ready request and response.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ALU_OP_LEN-1:0] req_op,
  input  logic [XLEN-1:0]       req_a,
  input  logic [XLEN-1:0]       req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_data,
  output logic                  resp_zero,
  output logic                  resp_neg,
  output logic                  resp_dbz,
  output logic                  resp_err,
  output logic                  busy
);

  md_state_e state_q, state_d;

  logic [ALU_OP_LEN-1:0] op_q;
  logic [XLEN-1:0]       a_q, b_q, opnd_q;
  logic [2*XLEN-1:0]     acc_q, step_acc;
  logic                  step_qbit;
  logic [CNT_W-1:0]      cnt_q;
  logic                  neg_q;

  logic                  resp_valid_q, resp_zero_q, resp_neg_q, resp_dbz_q, resp_err_q;
  logic [XLEN-1:0]       resp_data_q;

  logic                  is_mul, is_div, is_mod, op_ok, dbz_case;
  logic [XLEN-1:0]       mag, res;
  logic                  res_dbz, res_err;

  assign is_mul   = (op_q == ALU_OP_MUL);
  assign is_div   = (op_q == ALU_OP_DIV);
  assign is_mod   = (op_q == ALU_OP_MOD);
  assign op_ok    = is_mul | is_div | is_mod;
  assign dbz_case = (is_div | is_mod) && (b_q == '0);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (!is_mul),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .qbit_o (step_qbit)
  );

  // Next-state decode; flush overrides every transition.
  always_comb begin
    state_d   = state_q;
    req_ready = (state_q == MD_ST_IDLE);
    busy      = (state_q != MD_ST_IDLE);
    case (state_q)
      MD_ST_IDLE: if (req_valid) state_d = MD_ST_PREP;
      MD_ST_PREP: state_d = (!op_ok || dbz_case) ? MD_ST_FIX : MD_ST_CALC;
      MD_ST_CALC: if (cnt_q == '0) state_d = MD_ST_FIX;
      MD_ST_FIX:  state_d = MD_ST_DONE;
      MD_ST_DONE: if (resp_ready) state_d = MD_ST_IDLE;
      default:    state_d = MD_ST_IDLE;
    endcase
    if (flush) state_d = MD_ST_IDLE;
  end

  // Sign correction and result select for the FIX state.
  always_comb begin
    res     = '0;
    mag     = '0;
    res_dbz = 1'b0;
    res_err = 1'b0;
    if (!op_ok) begin
      res_err = 1'b1;
    end else if (dbz_case) begin
      res_dbz = 1'b1;
      res     = is_div ? MD_DBZ_QUOT : a_q;
    end else begin
      mag = is_mod ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      res = neg_q ? (~mag + 1'b1) : mag;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MD_ST_IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, iteration datapath and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      opnd_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      neg_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
      resp_neg_q   <= 1'b0;
      resp_dbz_q   <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        MD_ST_IDLE: begin
          if (req_valid && !flush) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
          end
        end
        MD_ST_PREP: begin
          acc_q  <= {{XLEN{1'b0}}, (is_mul ? md_abs(b_q) : md_abs(a_q))};
          opnd_q <= is_mul ? md_abs(a_q) : md_abs(b_q);
          neg_q  <= is_mod ? a_q[XLEN-1] : (a_q[XLEN-1] ^ b_q[XLEN-1]);
          cnt_q  <= CNT_W'(XLEN - 1);
        end
        MD_ST_CALC: begin
          // Divide steps leave bit 0 clear for the quotient bit; multiply steps report qbit 0.
          acc_q <= {step_acc[2*XLEN-1:1], step_acc[0] | step_qbit};
          cnt_q <= cnt_q - 1'b1;
        end
        MD_ST_FIX: begin
          if (!flush) begin
            resp_data_q <= res;
            resp_zero_q <= (res == '0);
            resp_neg_q  <= res[XLEN-1];
            resp_dbz_q  <= res_dbz;
            resp_err_q  <= res_err;
          end
        end
        default: ;
      endcase
      resp_valid_q <= (state_d == MD_ST_DONE);
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_zero  = resp_zero_q;
  assign resp_neg   = resp_neg_q;
  assign resp_dbz   = resp_dbz_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized and directed checks of alu_muldiv_seq against a signed-arithmetic reference.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flush = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic [ALU_OP_LEN-1:0] req_op = '0;
  logic [31:0]           req_a = '0;
  logic [31:0]           req_b = '0;
  logic                  resp_valid;
  logic                  resp_ready = 1'b0;
  logic [31:0]           resp_data;
  logic                  resp_zero, resp_neg, resp_dbz, resp_err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_zero  (resp_zero),
    .resp_neg   (resp_neg),
    .resp_dbz   (resp_dbz),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic, truncated to 32 bits.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic dbz, output logic err,
                                    output int lat);
    longint sa, sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    err = 1'b0;
    lat = 35;
    r   = '0;
    if (op == ALU_OP_MUL) begin
      r = 32'(sa * sb);
    end else if (op == ALU_OP_DIV || op == ALU_OP_MOD) begin
      if (b == 32'd0) begin
        dbz = 1'b1;
        lat = 3;
        r   = (op == ALU_OP_DIV) ? 32'hFFFF_FFFF : a;
      end else begin
        r = (op == ALU_OP_DIV) ? 32'(sa / sb) : 32'(sa % sb);
      end
    end else begin
      err = 1'b1;
      lat = 3;
    end
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] er;
    logic        edbz, eerr;
    int          elat, n;
    logic        ctl_bad, hold_bad;
    ref_model(op, a, b, er, edbz, eerr, elat);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    ctl_bad = 1'b0;
    while (!resp_valid && n < 100) begin
      if (!busy || req_ready) ctl_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n + 1), 32'(elat));
    chk("busy_ready_during_op", {31'b0, ctl_bad}, 32'd0);
    chk("data", resp_data, er);
    chk("zero", {31'b0, resp_zero}, {31'b0, er == 32'd0});
    chk("neg",  {31'b0, resp_neg},  {31'b0, er[31]});
    chk("dbz",  {31'b0, resp_dbz},  {31'b0, edbz});
    chk("err",  {31'b0, resp_err},  {31'b0, eerr});
    hold_bad = 1'b0;
    req_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!resp_valid || req_ready || !busy || resp_data !== er) hold_bad = 1'b1;
    end
    if (hold > 0) chk("hold_stable", {31'b0, hold_bad}, 32'd0);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("valid_drop", {31'b0, resp_valid}, 32'd0);
    chk("idle_ready", {30'b0, req_ready, busy}, 32'd2);
    chk("data_held", resp_data, er);
  endtask

  logic [3:0]  op_r;
  logic [31:0] a_r, b_r;
  logic        seen_valid;

  initial begin
    #1;
    chk("rst_ctl",  {29'b0, req_ready, busy, resp_valid}, 32'd4);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_flags", {28'b0, resp_zero, resp_neg, resp_dbz, resp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(ALU_OP_MUL, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(ALU_OP_MOD, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(ALU_OP_MOD, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(ALU_OP_DIV, 32'd5, 32'd0, 0);
    run_op(ALU_OP_MOD, 32'd5, 32'd0, 0);
    run_op(ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(ALU_OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(4'h0, 32'd12, 32'd34, 0);
    run_op(ALU_OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 10);

    // Flush during CALC: abort just before edge 10.
    @(negedge clk);
    req_valid = 1'b1; req_op = ALU_OP_MUL; req_a = 32'd9; req_b = 32'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {30'b0, req_ready, busy}, 32'd2);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (resp_valid || busy) seen_valid = 1'b1;
    end
    chk("flush_no_resp", {31'b0, seen_valid}, 32'd0);

    // Flush with a request in IDLE: not accepted.
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_blocks_accept", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op_r = ALU_OP_MUL;
        3, 4, 5: op_r = ALU_OP_DIV;
        6, 7, 8: op_r = ALU_OP_MOD;
        default: op_r = 4'hF;
      endcase
      a_r = $urandom;
      b_r = $urandom;
      case ($urandom_range(0, 5))
        0: b_r = 32'd0;
        1: begin a_r = 32'h8000_0000; b_r = 32'hFFFF_FFFF; end
        2: b_r = {{28{b_r[31]}}, b_r[3:0]};
        3: a_r = {{24{a_r[31]}}, a_r[7:0]};
        default: ;
      endcase
      run_op(op_r, a_r, b_r, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset between edges during CALC.
    @(negedge clk);
    req_valid = 1'b1; req_op = ALU_OP_MUL; req_a = 32'd3; req_b = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_ctl",  {29'b0, req_ready, busy, resp_valid}, 32'd4);
    chk("arst_data", resp_data, 32'd0);
    chk("arst_flags", {28'b0, resp_zero, resp_neg, resp_dbz, resp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(ALU_OP_MUL, 32'h0001_0000, 32'h0001_0000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
